// File: rtl/sv_mod_inv.sv
// sv_mod_inv: modular inverse x^-1 mod q by binary extended gcd, ROUND_PER_TACT rounds/clock; define SV_MOD_INV_EARLY_EXIT_EN for early exit on b==0
module sv_mod_inv_round #(
  parameter int W = 512,
  parameter int R = 1
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] p_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] s_o,
  output logic [W-1:0] p_o
);
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] v, input logic [W-1:0] m);
    logic [W:0] t;
    t = {1'b0, v} + (v[0] ? {1'b0, m} : '0);
    return t[W:1];
  endfunction
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] u, input logic [W-1:0] v, input logic [W-1:0] m);
    return u - v + (u >= v ? '0 : m);
  endfunction
  logic [W-1:0] a [R+1];
  logic [W-1:0] b [R+1];
  logic [W-1:0] s [R+1];
  logic [W-1:0] p [R+1];
  assign a[0] = a_i;
  assign b[0] = b_i;
  assign s[0] = s_i;
  assign p[0] = p_i;
  genvar g;
  for (g = 0; g < R; g++) begin : rnd
    logic odd, ge;
    assign odd = b[g][0];
    assign ge = b[g] >= a[g];
    assign a[g+1] = odd && !ge ? b[g] : a[g];
    assign b[g+1] = !odd ? b[g] >> 1 : ge ? (b[g] - a[g]) >> 1 : (a[g] - b[g]) >> 1;
    assign s[g+1] = odd && !ge ? p[g] : s[g];
    assign p[g+1] = half_mod(!odd ? p[g] : ge ? sub_mod(p[g], s[g], q) : sub_mod(s[g], p[g], q), q);
  end
  assign a_o = a[R];
  assign b_o = b[R];
  assign s_o = s[R];
  assign p_o = p[R];
endmodule

module sv_mod_inv #(
  parameter int DATA_WIDTH = 512,
  parameter int ROUND_PER_TACT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  err_o,
  output logic                  valid_o,
  input  logic                  ready_i
);
  localparam int N = (2 * DATA_WIDTH + ROUND_PER_TACT - 1) / ROUND_PER_TACT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] q_r, a_r, b_r, s_r, p_r, a_n, b_n, s_n, p_n, red;
  logic err_r, bad, last, fail;
  sv_mod_inv_round #(.W(DATA_WIDTH), .R(ROUND_PER_TACT)) u_round (
    .q(q_r), .a_i(a_r), .b_i(b_r), .s_i(s_r), .p_i(p_r),
    .a_o(a_n), .b_o(b_n), .s_o(s_n), .p_o(p_n)
  );
  assign bad = x_i == '0 || x_i >= q_i || !q_i[0];
`ifdef SV_MOD_INV_EARLY_EXIT_EN
  assign last = cnt == CW'(N - 1) || b_r == '0;
`else
  assign last = cnt == CW'(N - 1);
`endif
  assign fail = err_r || a_r != DATA_WIDTH'(1);
  assign red = s_r >= q_r ? s_r - q_r : s_r;
  always_comb begin
    state_n = state == IDLE ? (valid_i ? (bad ? DONE : RUN) : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : (ready_i ? IDLE : DONE);
    ready_o = state == IDLE;
    valid_o = state == DONE;
    err_o = valid_o && fail;
    res_o = valid_o && !fail ? red : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      q_r <= '0;
      a_r <= '0;
      b_r <= '0;
      s_r <= '0;
      p_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && valid_i) begin
        q_r <= q_i;
        a_r <= q_i;
        b_r <= x_i;
        s_r <= '0;
        p_r <= DATA_WIDTH'(1);
        cnt <= '0;
        err_r <= bad;
      end else if (state == RUN) begin
        a_r <= a_n;
        b_r <= b_n;
        s_r <= s_n;
        p_r <= p_n;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sv_mod_inv.sv
// tb_sv_mod_inv: randomized and directed checks of sv_mod_inv against an extended-Euclid model
module tb_sv_mod_inv;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
  logic [W-1:0] q_i = '0, x_i = '0;
  logic ro [2];
  logic vo [2];
  logic eo [2];
  logic [W-1:0] res [2];
  int nn [2] = '{16, 6};
  bit busy [2];
  bit seen [2];
  int age [2];
  int need [2];
  logic [W-1:0] er [2];
  logic ee [2];
  int checks = 0, fails = 0;
  sv_mod_inv #(.DATA_WIDTH(W), .ROUND_PER_TACT(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .q_i(q_i), .x_i(x_i), .valid_i(valid_i), .ready_o(ro[0]),
    .res_o(res[0]), .err_o(eo[0]), .valid_o(vo[0]), .ready_i(ready_i)
  );
  sv_mod_inv #(.DATA_WIDTH(W), .ROUND_PER_TACT(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .q_i(q_i), .x_i(x_i), .valid_i(valid_i), .ready_o(ro[1]),
    .res_o(res[1]), .err_o(eo[1]), .valid_o(vo[1]), .ready_i(ready_i)
  );
  always #5 clk = ~clk;
  function automatic void model(input int q, input int x, output logic [W-1:0] r, output logic e);
    int r0, r1, t0, t1, qt, tmp;
    e = 1'b1;
    r = '0;
    if (x == 0 || x >= q || q % 2 == 0) return;
    r0 = q; r1 = x; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      qt = r0 / r1;
      tmp = r0 - qt * r1; r0 = r1; r1 = tmp;
      tmp = t0 - qt * t1; t0 = t1; t1 = tmp;
    end
    if (r0 == 1) begin
      e = 1'b0;
      r = W'(t0 < 0 ? t0 + q : t0);
    end
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) busy[k] = 1'b0;
      else if (!busy[k]) begin
        if (valid_i) begin
          busy[k] = 1'b1;
          seen[k] = 1'b0;
          age[k] = 1;
          model(int'(q_i), int'(x_i), er[k], ee[k]);
          need[k] = ee[k] && (x_i == 0 || x_i >= q_i || !q_i[0]) ? 1 : nn[k] + 1;
        end
      end else begin
`ifdef SV_MOD_INV_EARLY_EXIT_EN
        if (vo[k]) seen[k] = 1'b1;
        if (seen[k] && ready_i) busy[k] = 1'b0;
`else
        if (age[k] >= need[k] && ready_i) busy[k] = 1'b0;
`endif
        else age[k]++;
      end
    end
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ev, ok;
      logic [W-1:0] xr;
      logic xe;
`ifdef SV_MOD_INV_EARLY_EXIT_EN
      ev = busy[k] && (seen[k] || vo[k] || age[k] >= need[k]);
`else
      ev = busy[k] && age[k] >= need[k];
`endif
      xr = ev ? er[k] : '0;
      xe = ev ? ee[k] : 1'b0;
      ok = ro[k] == !busy[k] && vo[k] == ev && res[k] == xr && eo[k] == xe;
      checks++;
      if (!ok) begin
        fails++;
        $display("FAIL cmp dut%0d t=%0t: got ready=%b valid=%b res=%0d err=%b, required ready=%b valid=%b res=%0d err=%b",
                 k, $time, ro[k], vo[k], res[k], eo[k], !busy[k], ev, xr, xe);
      end
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", n, act, exp);
    end
  endtask
  task automatic accept(input int q, input int x);
    int w;
    @(negedge clk);
    q_i = W'(q);
    x_i = W'(x);
    valid_i = 1'b1;
    ready_i = 1'b0;
    w = 0;
    while (!ro[0] && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", int'(w < 200), 1);
    @(posedge clk);
    #1;
    q_i = W'($urandom);
    x_i = W'($urandom);
  endtask
  task automatic job(input int q, input int x, input int rexp, input int eexp, input int lexp);
    int lat;
    logic [W-1:0] r0;
    accept(q, x);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vo[0] && lat < 100);
`ifdef SV_MOD_INV_EARLY_EXIT_EN
    chk("latency_bound", int'(lexp == 1 ? lat == 1 : lat >= 2 && lat <= lexp), 1);
`else
    chk("latency", lat, lexp);
`endif
    chk("res", int'(res[0]), rexp);
    chk("err", int'(eo[0]), eexp);
    r0 = res[0];
    repeat (5) begin
      @(negedge clk);
      chk("hold", int'({vo[0], ro[0], res[0]}), int'({1'b1, 1'b0, W'(rexp)}));
    end
    chk("hold_res", int'(r0), rexp);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("ready_after", int'({ro[0], vo[0]}), 2);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset", int'({ro[k], vo[k], eo[k], res[k]}), int'({1'b1, 1'b0, 1'b0, W'(0)}));
    rst = 1'b0;
    job(251, 3, 84, 0, 17);
    job(251, 0, 0, 1, 1);
    job(251, 251, 0, 1, 1);
    job(15, 6, 0, 1, 17);
    job(250, 3, 0, 1, 1);
    job(251, 250, 250, 0, 17);
    job(255, 2, 128, 0, 17);
    job(3, 1, 1, 0, 17);
    accept(251, 3);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_run", int'({ro[0], vo[0], ro[1], vo[1]}), 4'b1010);
    job(251, 2, 126, 0, 17);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      q_i = $urandom_range(0, 7) == 0 ? W'($urandom_range(1, 127) * 2) : W'($urandom_range(1, 127) * 2 + 1);
      x_i = W'($urandom_range(0, int'(q_i)));
      valid_i = $urandom_range(0, 2) != 0;
      ready_i = $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 299) == 0;
    end
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sv_mod_inv.md
SV_MOD_INV -- requirements
Module: sv_mod_inv

Interface
REQ-001 Parameter DATA_WIDTH, default 512, SHALL set the operand width in bits.
REQ-002 Parameter ROUND_PER_TACT, default 1, SHALL set the inversion rounds evaluated per clock; legal range 1..2*DATA_WIDTH.
REQ-003 Port clk_i, input, 1 bit, SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst_i, input, 1 bit, SHALL be the reset, synchronous, active-high.
REQ-005 Port q_i, input, DATA_WIDTH bits, SHALL carry the modulus, odd, >1.
REQ-006 Port x_i, input, DATA_WIDTH bits, SHALL carry the value to invert.
REQ-007 Port valid_i, input, 1 bit, SHALL mark q_i/x_i valid.
REQ-008 Port ready_o, output, 1 bit, SHALL mark the block able to accept a request.
REQ-009 Port res_o, output, DATA_WIDTH bits, SHALL carry x^-1 mod q.
REQ-010 Port err_o, output, 1 bit, SHALL flag an invalid operand, qualified by valid_o.
REQ-011 Port valid_o, output, 1 bit, SHALL mark res_o/err_o valid.
REQ-012 Port ready_i, input, 1 bit, SHALL mark the consumer accepting the result.

Function
REQ-013 The block SHALL instantiate the team's combinational inversion round stage once (q, a, b, s, p in/out, ROUND_PER_TACT rounds) and register its a/b/s/p outputs every RUN cycle.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; ready_o=1 only in IDLE.
REQ-015 IDLE with valid_i=1 SHALL latch q_i into a q register, load a=q_i, b=x_i, s=0, p=1, clear the round counter, and go to RUN; the accepted operands are the values present on that edge.
REQ-016 Acceptance SHALL check operands: x_i==0, x_i>=q_i, or q_i even SHALL go to DONE directly with err_o=1, res_o=0, and no rounds run.
REQ-017 RUN SHALL last exactly N=ceil(2*DATA_WIDTH/ROUND_PER_TACT) cycles; counter width $clog2(N+1); on the N-th cycle go to DONE.
REQ-018 Latency from the accepting edge to valid_o=1 SHALL be N+1 cycles for valid operands and 1 cycle for errored ones.
REQ-019 In DONE, valid_o=1; res_o SHALL equal registered s, reduced once (s-q if s>=q); err_o=0 for valid operands.
REQ-020 If a is not 1 after the final round (gcd(x,q)!=1), err_o SHALL be 1 and res_o 0.
REQ-021 DONE SHALL hold res_o/err_o/valid_o stable until ready_i=1, then go to IDLE on that edge; ready_o SHALL rise the cycle after.
REQ-022 valid_i in RUN or DONE SHALL be ignored; no request is queued.
REQ-023 res_o and err_o SHALL be 0 whenever valid_o=0.

Reset
REQ-024 rst_i=1 on a clock edge SHALL force IDLE, ready_o=1, valid_o=0, res_o=0, err_o=0, counter=0, a/b/s/p/q registers=0.
REQ-025 Reset SHALL take priority over every transition, including mid-RUN and in DONE with ready_i=1; the in-flight operation SHALL be dropped without producing valid_o.

Configuration
REQ-026 Macro SV_MOD_INV_EARLY_EXIT_EN SHALL control early termination.
REQ-027 With the macro defined, RUN SHALL go to DONE at the end of the first cycle whose registered b equals 0; latency is variable, at most N+1.
REQ-028 Without the macro, RUN SHALL always last exactly N cycles (constant time, required for key material); no b==0 comparator is synthesised.

Verification
REQ-029 DATA_WIDTH=8, ROUND_PER_TACT=1, q=251, x=3 -> valid_o after 17 cycles, res_o=84, err_o=0.
REQ-030 q=251, x=0, then x=251 -> valid_o 1 cycle after accept, err_o=1, res_o=0 in both cases.
REQ-031 DATA_WIDTH=8, q=15, x=6 -> err_o=1, res_o=0 after full latency.
REQ-032 ready_i held 0 for 5 cycles in DONE -> res_o/valid_o stable throughout; ready_o=1 one cycle after ready_i=1.
REQ-033 rst_i pulsed at RUN cycle 4, then new request q=251, x=2 -> no valid_o from the first job; second gives res_o=126.
REQ-034 ROUND_PER_TACT=4, DATA_WIDTH=512, 1000 random (q prime, x) pairs against a model -> all match, latency 257 without SV_MOD_INV_EARLY_EXIT_EN, at most 257 with it.
